// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and default width for serial_sub_ctrl
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_sub_ctrl_fs_cell.sv
// rtl/serial_sub_ctrl_fs_cell.sv - one-bit full subtractor from two half subtractors
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);
  assign d  = x ^ y;
  assign bo = ~x & y;
endmodule

module fs_cell (
  input  logic ai,
  input  logic bi,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic w_d1, w_b1, w_b2;

  half_subtractor u_hs0 (.x(ai),   .y(bi),  .d(w_d1), .bo(w_b1));
  half_subtractor u_hs1 (.x(w_d1), .y(bin), .d(d),    .bo(w_b2));

  assign bout = w_b1 | w_b2;
endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial a-b controller, one bit per cycle LSB first
// Optional registered zero flag port enabled by SERIAL_SUB_ZERO_FLAG_EN
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_diff;
  logic             r_borrow;
  logic             w_accept, w_run, w_last, w_d, w_bout;

  fs_cell u_fs_cell (
    .ai  (r_a[0]),
    .bi  (r_b[0]),
    .bin (r_borrow),
    .d   (w_d),
    .bout(w_bout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_run       = 1'b0;
    w_last      = (r_cnt == LAST);
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_accept    = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy  = 1'b1;
        w_run = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operands shift right so the cell always sees the current bit at index 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_a      <= a;
      r_b      <= b;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if (w_run) begin
      r_diff[r_cnt] <= w_d;
      r_borrow      <= w_bout;
      r_a           <= r_a >> 1;
      r_b           <= r_b >> 1;
      if (!w_last) r_cnt <= r_cnt + CW'(1);
    end
  end

  assign diff   = r_diff;
  assign borrow = r_borrow;

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic r_zero;

  // The MSB is still in flight on the final edge, so fold w_d in directly
  always_ff @(posedge clk) begin
    if (!rst_n)                r_zero <= 1'b1;
    else if (w_run && w_last)  r_zero <= ~(w_d | (|r_diff[WIDTH-2:0]));
  end

  assign zero = r_zero;
`endif

endmodule
